// File: rtl/ram_arbiter_1r_1w_pkg.sv
// ram_arbiter_pkg: shared types and helpers for the 1R/1W RAM arbiter.
//
// Contents:
//   NUM_REQ_DEF    requester count the id_t type is sized for
//   ID_WIDTH       width of a requester index for NUM_REQ_DEF requesters
//   MAX_REQ        largest supported requester count
//   id_t           requester index type; the arbiter checks at elaboration
//                  that this matches its own ID_WIDTH
//   onehot_to_idx  converts a one-hot (or zero) grant vector to an index
package ram_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int ID_WIDTH    = $clog2(NUM_REQ_DEF);
  localparam int MAX_REQ     = 16;

  typedef logic [ID_WIDTH-1:0] id_t;

  // OR together the indices of all set bits; for a one-hot input this is
  // the index of the single set bit, and a zero input yields index 0.
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = idx | (onehot[i] ? 4'(i) : 4'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_arbiter_1r_1w_if.sv
// ram_arbiter_1r_1w_if: requester-side bus of the shared-RAM arbiter.
//
// Signals (one lane per requester unless noted):
//   aReadRequest / aReadAddress     read request and address
//   anOutReadGrant                  combinational read grant, one-hot or zero
//   anOutReadValid                  read-data strobe, one cycle after grant
//   anOutReadData                   read data, broadcast to all requesters
//   aWriteRequest / aWriteAddress / aWriteData   write request, address, data
//   anOutWriteGrant                 combinational write grant, one-hot or zero
//
// Modports: master = requester side, slave = arbiter side.
interface ram_arbiter_1r_1w_if #(
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 4
);

  logic [NUM_REQ-1:0]                 aReadRequest;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] aReadAddress;
  logic [NUM_REQ-1:0]                 anOutReadGrant;
  logic [NUM_REQ-1:0]                 anOutReadValid;
  logic [DEPTH-1:0]                   anOutReadData;
  logic [NUM_REQ-1:0]                 aWriteRequest;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] aWriteAddress;
  logic [NUM_REQ-1:0][DEPTH-1:0]      aWriteData;
  logic [NUM_REQ-1:0]                 anOutWriteGrant;

  modport master (
    output aReadRequest, aReadAddress,
    input  anOutReadGrant, anOutReadValid, anOutReadData,
    output aWriteRequest, aWriteAddress, aWriteData,
    input  anOutWriteGrant
  );

  modport slave (
    input  aReadRequest, aReadAddress,
    output anOutReadGrant, anOutReadValid, anOutReadData,
    input  aWriteRequest, aWriteAddress, aWriteData,
    output anOutWriteGrant
  );

endinterface

// File: rtl/ram_arbiter_1r_1w_rr_arbiter.sv
// rr_arbiter: round-robin arbiter for one RAM port.
//
// Ports:
//   aClock    clock, rising edge
//   aResetN   synchronous active-low reset; also masks requests and grants
//   request   per-requester request vector
//   grant     combinational grant, one-hot or zero
//
// The pointer names the highest-priority requester; after a grant to i it
// moves to (i+1) mod NUM_REQ and it holds when nobody requests.
//
// Optional feature (macro RAM_ARBITER_BURST_EN): the current owner may keep
// the grant for up to MAX_BURST consecutive cycles while it keeps
// requesting. Without the macro the arbiter is pure round robin.
module rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               aClock,
  input  logic               aResetN,
  input  logic [NUM_REQ-1:0] request,
  output logic [NUM_REQ-1:0] grant
);

  localparam int ID_WIDTH = $clog2(NUM_REQ);

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("rr_arbiter: MAX_BURST must be at least 1");
  end

  logic [ID_WIDTH-1:0] ptr_r;
  logic [ID_WIDTH-1:0] ptr_next_s;
  logic [NUM_REQ-1:0]  req_s;
  logic [NUM_REQ-1:0]  scan_grant_s;
  logic [ID_WIDTH-1:0] scan_idx_s;
  logic                scan_hit_s;

  // Requests seen while reset is asserted are ignored.
  assign req_s = aResetN ? request : '0;

  // Scan from the pointer with wrap and pick the first active requester.
  always_comb begin
    logic [ID_WIDTH-1:0] idx_v;
    logic                take_v;
    scan_grant_s = '0;
    scan_idx_s   = '0;
    scan_hit_s   = 1'b0;
    idx_v        = '0;
    take_v       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_v  = ID_WIDTH'((int'(ptr_r) + i) % NUM_REQ);
      take_v = !scan_hit_s && req_s[idx_v];
      if (take_v) begin
        scan_grant_s[idx_v] = 1'b1;
        scan_idx_s          = idx_v;
      end else begin
        scan_idx_s = scan_idx_s;
      end
      scan_hit_s = scan_hit_s | take_v;
    end
  end

  // Pointer value after a scan grant: one past the winner, modulo NUM_REQ.
  assign ptr_next_s = (scan_idx_s == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                             : scan_idx_s + ID_WIDTH'(1);

`ifdef RAM_ARBITER_BURST_EN

  localparam int CNT_WIDTH = $clog2(MAX_BURST) + 1;

  // cnt_r counts extra grants already given to owner_r in the current burst.
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [ID_WIDTH-1:0]  owner_r;
  logic                 owner_vld_r;
  logic                 keep_s;

  assign keep_s = owner_vld_r && req_s[owner_r] &&
                  (cnt_r < CNT_WIDTH'(MAX_BURST - 1));

  // Grant the owner while its burst lasts, otherwise the round-robin winner.
  always_comb begin
    grant = '0;
    if (keep_s) begin
      grant[owner_r] = 1'b1;
    end else begin
      grant = scan_grant_s;
    end
  end

  // Pointer, owner and burst counter; the pointer stays put during a burst.
  always_ff @(posedge aClock) begin
    if (!aResetN) begin
      ptr_r       <= '0;
      cnt_r       <= '0;
      owner_r     <= '0;
      owner_vld_r <= 1'b0;
    end else if (keep_s) begin
      cnt_r <= cnt_r + CNT_WIDTH'(1);
    end else if (scan_hit_s) begin
      ptr_r       <= ptr_next_s;
      owner_r     <= scan_idx_s;
      owner_vld_r <= 1'b1;
      cnt_r       <= '0;
    end else begin
      owner_vld_r <= 1'b0;
      cnt_r       <= '0;
    end
  end

`else

  // Pure round robin: the scan result is the grant.
  always_comb begin
    grant = scan_grant_s;
  end

  // Rotating priority pointer; holds when nobody is granted.
  always_ff @(posedge aClock) begin
    if (!aResetN) begin
      ptr_r <= '0;
    end else if (scan_hit_s) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

`endif

endmodule

// File: rtl/ram_arbiter_1r_1w.sv
// ram_arbiter_1r_1w: shares one 1R/1W RAM among NUM_REQ requesters.
//
// Ports:
//   aClock, aResetN           clock and synchronous active-low reset
//   bus (slave modport)       requester handshake: requests, addresses,
//                             write data, grants, read valid and read data
//   anOutRamReadAddress / anOutRamReadEnable                 RAM read port
//   aRamReadData              RAM read data, one cycle after the enable
//   anOutRamWriteAddress / anOutRamWriteData / anOutRamWriteEnable  RAM write port
//
// Read and write ports are arbitrated independently by two rr_arbiter
// instances. The read winner's index is registered so the returning RAM
// data is flagged to that requester one cycle later. With no grant the RAM
// address and write-data buses are driven to zero.
//
// Optional feature: define RAM_ARBITER_BURST_EN to let a requester hold a
// port for up to MAX_BURST consecutive grants.
module ram_arbiter_1r_1w
  import ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DEPTH     = 8,
  parameter int SIZE      = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                     aClock,
  input  logic                     aResetN,
  ram_arbiter_1r_1w_if.slave       bus,
  output logic [$clog2(SIZE)-1:0]  anOutRamReadAddress,
  output logic                     anOutRamReadEnable,
  input  logic [DEPTH-1:0]         aRamReadData,
  output logic [$clog2(SIZE)-1:0]  anOutRamWriteAddress,
  output logic [DEPTH-1:0]         anOutRamWriteData,
  output logic                     anOutRamWriteEnable
);

  localparam int ADDR_WIDTH = $clog2(SIZE);
  localparam int ID_WIDTH   = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || $bits(id_t) != ID_WIDTH) begin : g_bad_cfg
    $error("ram_arbiter_1r_1w: NUM_REQ must be 2..16 and match ram_arbiter_pkg::id_t");
  end

  logic [NUM_REQ-1:0]    rd_grant_s;
  logic [NUM_REQ-1:0]    wr_grant_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DEPTH-1:0]      wr_data_s;
  id_t                   rd_id_s;
  id_t                   rd_id_r;
  logic                  rd_pending_r;
  logic [NUM_REQ-1:0]    rd_valid_s;
  logic [DEPTH-1:0]      rd_data_s;

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST)
  ) u_rd_arb (
    .aClock  (aClock),
    .aResetN (aResetN),
    .request (bus.aReadRequest),
    .grant   (rd_grant_s)
  );

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST)
  ) u_wr_arb (
    .aClock  (aClock),
    .aResetN (aResetN),
    .request (bus.aWriteRequest),
    .grant   (wr_grant_s)
  );

  // AND-OR muxes: grants are one-hot or zero, so no grant gives all zeros.
  always_comb begin
    rd_addr_s = '0;
    wr_addr_s = '0;
    wr_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_addr_s = rd_addr_s | (rd_grant_s[i] ? bus.aReadAddress[i]  : '0);
      wr_addr_s = wr_addr_s | (wr_grant_s[i] ? bus.aWriteAddress[i] : '0);
      wr_data_s = wr_data_s | (wr_grant_s[i] ? bus.aWriteData[i]    : '0);
    end
  end

  assign rd_id_s = id_t'(onehot_to_idx(MAX_REQ'(rd_grant_s)));

  // Remember which requester owns the read that the RAM returns next cycle.
  always_ff @(posedge aClock) begin
    if (!aResetN) begin
      rd_pending_r <= 1'b0;
      rd_id_r      <= '0;
    end else begin
      rd_pending_r <= |rd_grant_s;
      rd_id_r      <= rd_id_s;
    end
  end

  // Return path; gated by reset so a read granted just before reset is dropped.
  always_comb begin
    rd_valid_s = '0;
    rd_data_s  = '0;
    if (rd_pending_r && aResetN) begin
      rd_valid_s[rd_id_r] = 1'b1;
      rd_data_s           = aRamReadData;
    end else begin
      rd_valid_s = '0;
      rd_data_s  = '0;
    end
  end

  assign bus.anOutReadGrant  = rd_grant_s;
  assign bus.anOutWriteGrant = wr_grant_s;
  assign bus.anOutReadValid  = rd_valid_s;
  assign bus.anOutReadData   = rd_data_s;

  assign anOutRamReadEnable   = |rd_grant_s;
  assign anOutRamReadAddress  = rd_addr_s;
  assign anOutRamWriteEnable  = |wr_grant_s;
  assign anOutRamWriteAddress = wr_addr_s;
  assign anOutRamWriteData    = wr_data_s;

endmodule

// File: doc/ram_arbiter_1r_1w.md
# ram_arbiter_1r_1w

Round-robin arbiter that shares one single-read/single-write RAM among NUM_REQ requesters. Read and write ports are arbitrated independently, each with its own rotating priority pointer. The block drives the RAM's address, enable and write-data ports and routes the registered read data back to the requester that issued the read. It sits between the pipeline clients (fetch, load/store, DMA) and a shared scratch memory.

## Interface
- NUM_REQ, 4, number of requesters; legal values are 2..16.
- DEPTH, 8, data word width in bits.
- SIZE, 16, number of RAM entries. ADDR_WIDTH = $clog2(SIZE); ID_WIDTH = $clog2(NUM_REQ).
- MAX_BURST, 4, maximum number of consecutive grants to one requester. Used only when the burst feature is compiled in (see Configuration).

Ports:
- aClock  in  1  sole clock; all logic is on its rising edge.
- aResetN  in  1  reset, synchronous and active-low.
- aReadRequest  in  NUM_REQ  per-requester read request.
- aReadAddress  in  NUM_REQ x ADDR_WIDTH  per-requester read address.
- anOutReadGrant  out  NUM_REQ  one-hot or zero; combinational grant.
- anOutReadValid  out  NUM_REQ  one-hot or zero; data-valid strobe to the requester that was granted.
- anOutReadData  out  DEPTH  read data, broadcast to all requesters.
- aWriteRequest  in  NUM_REQ  per-requester write request.
- aWriteAddress  in  NUM_REQ x ADDR_WIDTH  per-requester write address.
- aWriteData  in  NUM_REQ x DEPTH  per-requester write data.
- anOutWriteGrant  out  NUM_REQ  one-hot or zero; combinational grant.
- anOutRamReadAddress / anOutRamReadEnable  out  ADDR_WIDTH / 1  RAM read port.
- aRamReadData  in  DEPTH  RAM read data, one cycle after the read enable.
- anOutRamWriteAddress / anOutRamWriteData / anOutRamWriteEnable  out  ADDR_WIDTH / DEPTH / 1  RAM write port.

## Operation
- Request/grant handshake:
  - A requester holds its request and its address/data stable until it sees its grant bit high.
  - A transfer completes in the cycle where request and grant are both high.
  - Dropping a request before it is granted is legal; no transfer occurs.
- Each port has a round-robin pointer (ID_WIDTH bits) that names the highest-priority requester.
  - Each cycle the first requester at or after the pointer, scanning with modulo-NUM_REQ wrap, is granted.
  - After a grant to requester i, the pointer becomes (i+1) mod NUM_REQ.
  - If no requester is active, the pointer holds.
- RAM port mapping:
  - anOutRamReadEnable = |anOutReadGrant; the RAM read address is muxed from the granted requester.
  - The write port is handled the same way.
  - When there is no grant, RAM addresses and write data are driven to 0.
- Read return path:
  - The granted ID and a pending bit are registered.
  - In the next cycle, anOutReadValid[id] = 1 and anOutReadData = aRamReadData.
  - When no read is pending, anOutReadData = 0.
- A read and a write to the same address in the same cycle return the new data; the RAM provides this bypass.
- Starvation bound: a continuously requesting client is granted within NUM_REQ cycles. With bursts enabled the bound is NUM_REQ × MAX_BURST cycles.

## Timing
- Grant is combinational, in the same cycle as the request. Read latency is exactly 1 cycle from grant to valid.
- Back-to-back reads are sustained at 1 per cycle.
- Reset (aResetN = 0 at a rising edge) sets:
  - both pointers to 0;
  - the pending bit and registered ID to 0;
  - burst counters to 0.
- Outputs during reset:
  - All grant outputs are forced to 0, as are both RAM enables.
  - anOutReadValid = 0 and anOutReadData = 0.
- Reset asserted in the cycle after a grant: the pending read is discarded and no valid is issued.
- Requests present while aResetN = 0 are ignored.

## Configuration
- RAM_ARBITER_BURST_EN defined:
  - Per port, a counter tracks consecutive grants to the current owner.
  - If the owner still requests and count < MAX_BURST-1, it keeps the grant and the pointer does not advance.
  - Otherwise the pointer rotates as above and the counter clears.
  - The counter also clears when the owner drops its request.
- RAM_ARBITER_BURST_EN undefined: pure round robin. The counters and the MAX_BURST logic are absent.

## Structure
- Package ram_arbiter_pkg holds:
  - the id_t typedef (ID_WIDTH bits), which must match the block's ID_WIDTH;
  - a function that converts a one-hot vector to an index.
- Sub-module rr_arbiter holds the pointer, grant scan and optional burst counter. It is instantiated twice, once for read and once for write. The top level adds the muxes and the read-return register.

## Test plan
- Reset then idle: all outputs are 0; the RAM enables stay 0 for 10 cycles.
- Req 2 reads address 5 holding 0xA5 → grant[2] in the request cycle; next cycle valid[2] = 1 and data = 0xA5.
- Reqs 0..3 read continuously with burst off → grants rotate 0,1,2,3,0; each valid follows its grant by one cycle.
- Same-cycle write of 0x3C to address 7 and read of address 7 by different requesters → read returns 0x3C.
- Burst on with MAX_BURST = 4, reqs 1 and 3 continuous → grants 1,1,1,1,3,3,3,3,1.
- Read granted at cycle N, reset at N+1 → no valid at N+1; the pointer is 0 afterwards.
